// File: rtl/seq_shift_add_mult.sv
// Iterative shift-and-add multiplier: one partial product per clock,
// WIDTH-bit operands, per-operation signed/unsigned mode, 2*WIDTH-bit product.
module seq_shift_add_mult #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ma, ma_nxt;
  logic [WIDTH-1:0] mb, mb_nxt;
  logic             neg, neg_nxt;
  logic [PW-1:0]    acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [PW-1:0]    p_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;

  // Unsigned magnitudes of the operands; |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is exact unsigned
  always_comb begin
    a_mag_c = a[WIDTH-1] ? WIDTH'(~a + WIDTH'(1)) : a;
    b_mag_c = b[WIDTH-1] ? WIDTH'(~b + WIDTH'(1)) : b;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    state_nxt = state;
    ma_nxt    = ma;
    mb_nxt    = mb;
    neg_nxt   = neg;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    p_nxt     = p;
    done_nxt  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
          ma_nxt    = sgn ? a_mag_c : a;
          mb_nxt    = sgn ? b_mag_c : b;
          neg_nxt   = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        if (mb[0]) begin
          acc_nxt = acc + (PW'(ma) << cnt);
        end
        mb_nxt  = mb >> 1;
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        // Negating a zero accumulator yields zero, so no special case is needed
        p_nxt     = neg ? PW'(~acc + PW'(1)) : acc;
        done_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ma   <= '0;
      mb   <= '0;
      neg  <= 1'b0;
      acc  <= '0;
      cnt  <= '0;
      p    <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      ma   <= ma_nxt;
      mb   <= mb_nxt;
      neg  <= neg_nxt;
      acc  <= acc_nxt;
      cnt  <= cnt_nxt;
      p    <= p_nxt;
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed and random checks of seq_shift_add_mult at WIDTH=8 and WIDTH=13.
module tb_seq_shift_add_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, sgn;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] p;

  logic        start13, sgn13;
  logic [12:0] a13, b13;
  logic        busy13, done13;
  logic [25:0] p13;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_shift_add_mult #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn), .a(a), .b(b),
    .busy(busy), .done(done), .p(p)
  );

  seq_shift_add_mult #(.WIDTH(13)) u_dut13 (
    .clk(clk), .rst(rst), .start(start13), .sgn(sgn13), .a(a13), .b(b13),
    .busy(busy13), .done(done13), .p(p13)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
    longint xi, yi;
    xi = s ? longint'($signed(x)) : longint'(x);
    yi = s ? longint'($signed(y)) : longint'(y);
    return 16'(xi * yi);
  endfunction

  function automatic logic [25:0] ref13(input logic [12:0] x, input logic [12:0] y, input logic s);
    longint xi, yi;
    xi = s ? longint'($signed(x)) : longint'(x);
    yi = s ? longint'($signed(y)) : longint'(y);
    return 26'(xi * yi);
  endfunction

  // One 8-bit operation: latency, busy length, product, single-cycle done
  task automatic run8(input logic [7:0] xa, input logic [7:0] xb, input logic xs,
                      input logic [15:0] exp_p, input string name);
    int n;
    int bcnt;
    start = 1'b1; a = xa; b = xb; sgn = xs;
    tick();
    start = 1'b0; a = ~xa; b = ~xb; sgn = ~xs;
    n = 0;
    bcnt = busy ? 1 : 0;
    while (!done && n < 40) begin
      tick();
      n++;
      if (busy) bcnt++;
    end
    n_cmp++;
    if (n !== 9) begin
      n_err++;
      $display("FAIL %s latency: got %0d edges, expected 9", name, n);
    end
    n_cmp++;
    if (p !== exp_p) begin
      n_err++;
      $display("FAIL %s product: got 0x%04h, expected 0x%04h", name, p, exp_p);
    end
    n_cmp++;
    if (bcnt !== 9) begin
      n_err++;
      $display("FAIL %s busy_len: got %0d cycles, expected 9", name, bcnt);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL %s done_pulse: got %0b, expected 0", name, done);
    end
  endtask

  // One 13-bit operation: latency and product
  task automatic run13(input logic [12:0] xa, input logic [12:0] xb, input logic xs);
    int n;
    logic [25:0] exp_p;
    exp_p = ref13(xa, xb, xs);
    start13 = 1'b1; a13 = xa; b13 = xb; sgn13 = xs;
    tick();
    start13 = 1'b0; a13 = ~xa; b13 = ~xb;
    n = 0;
    while (!done13 && n < 40) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n !== 14 || p13 !== exp_p) begin
      n_err++;
      $display("FAIL w13 op a=%0h b=%0h s=%0b: got p=0x%07h after %0d edges, expected 0x%07h after 14",
               xa, xb, xs, p13, n, exp_p);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; sgn = 1'b0; a = 8'd7; b = 8'd9;
    start13 = 1'b1; sgn13 = 1'b0; a13 = 13'd5; b13 = 13'd6;
    tick();
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || p !== 16'h0000) begin
      n_err++;
      $display("FAIL reset8: got busy=%0b done=%0b p=0x%04h, expected 0 0 0x0000", busy, done, p);
    end
    n_cmp++;
    if (busy13 !== 1'b0 || done13 !== 1'b0 || p13 !== 26'h0) begin
      n_err++;
      $display("FAIL reset13: got busy=%0b done=%0b p=0x%07h, expected 0 0 0", busy13, done13, p13);
    end
    start = 1'b0; start13 = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_signed_corners();
    run8(8'h80, 8'h80, 1'b1, 16'h4000, "s_m128xm128");
    run8(8'h80, 8'h7F, 1'b1, 16'hC080, "s_m128x127");
    run8(8'hFF, 8'h01, 1'b1, 16'hFFFF, "s_m1x1");
    run8(8'hFF, 8'h01, 1'b0, 16'h00FF, "u_255x1");
    run8(8'h00, 8'h80, 1'b1, 16'h0000, "s_0xm128");
    run8(8'h05, 8'hFD, 1'b1, 16'hFFF1, "s_5xm3");
  endtask

  task automatic test_hold();
    logic seen_done;
    logic p_bad;
    run8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_255x255");
    seen_done = 1'b0;
    p_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom); b = 8'($urandom); sgn = i[0]; start = 1'b0;
      tick();
      if (done !== 1'b0) seen_done = 1'b1;
      if (p !== 16'hFE01) p_bad = 1'b1;
    end
    n_cmp++;
    if (p_bad || seen_done) begin
      n_err++;
      $display("FAIL hold: got p=0x%04h done_seen=%0b, expected 0xfe01 0", p, seen_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] opa [30];
    logic [7:0] opb [30];
    logic       ops [30];
    logic       exp_done;
    logic       seen_done;
    for (int k = 0; k < 30; k++) begin
      opa[k] = 8'(k * 37 + 11);
      opb[k] = 8'(k * 53 + 200);
      ops[k] = k[0];
      start = 1'b1; a = opa[k]; b = opb[k]; sgn = ops[k];
      tick();
      exp_done = ((k % 10) == 9);
      n_cmp++;
      if (done !== exp_done) begin
        n_err++;
        $display("FAIL b2b done at edge %0d: got %0b, expected %0b", k, done, exp_done);
      end
      if (exp_done) begin
        n_cmp++;
        if (p !== ref8(opa[k-9], opb[k-9], ops[k-9])) begin
          n_err++;
          $display("FAIL b2b product at edge %0d: got 0x%04h, expected 0x%04h",
                   k, p, ref8(opa[k-9], opb[k-9], ops[k-9]));
        end
      end
    end
    start = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done !== 1'b0) seen_done = 1'b1;
    end
    n_cmp++;
    if (seen_done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b tail: got extra_done=%0b busy=%0b, expected 0 0", seen_done, busy);
    end
  endtask

  task automatic test_mid_reset();
    logic seen_done;
    start = 1'b1; a = 8'd200; b = 8'd100; sgn = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || p !== 16'h0000 || done !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got busy=%0b done=%0b p=0x%04h, expected 0 0 0x0000", busy, done, p);
    end
    start = 1'b1; a = 8'd9; b = 8'd9;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_start: got busy=%0b, expected 0", busy);
    end
    rst = 1'b0; start = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done !== 1'b0) seen_done = 1'b1;
    end
    n_cmp++;
    if (seen_done !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_no_done: got done_seen=%0b, expected 0", seen_done);
    end
    run8(8'd3, 8'd5, 1'b0, 16'd15, "after_reset_3x5");
  endtask

  task automatic test_accept_after_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0; start = 1'b1; a = 8'd2; b = 8'd2; sgn = 1'b0;
    tick();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL accept_after_rst: got busy=%0b, expected 1", busy);
    end
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_random();
    logic [7:0] ra, rb;
    logic       rs;
    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      run8(ra, rb, rs, ref8(ra, rb, rs), "rand8");
    end
    run13(13'h1000, 13'h1000, 1'b1);
    run13(13'h1FFF, 13'h1FFF, 1'b0);
    run13(13'h0000, 13'h1000, 1'b1);
    for (int i = 0; i < 40; i++) begin
      run13(13'($urandom), 13'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_signed_corners();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    test_accept_after_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
